// File: rtl/depth_dispatcher_if.sv
// depth_dispatcher_if: calculator start/done link plus the outgoing pixel stream.
// master = dispatcher side, slave = calculator and pixel sink side.
interface depth_dispatcher_if #(
   parameter int unsigned WORD_LENGTH = 64
);
   localparam int unsigned DEPTH_W = 10;

   // Calculator link
   logic                   calc_start;
   logic [WORD_LENGTH-1:0] calc_re_c;
   logic [WORD_LENGTH-1:0] calc_im_c;
   logic                   calc_done;
   logic [DEPTH_W-1:0]     calc_depth;

   // Pixel stream toward the colour/VGA path
   logic                   pix_valid;
   logic                   pix_ready;
   logic [DEPTH_W-1:0]     pix_depth;
   logic                   pix_sof;
   logic                   pix_eol;

   modport master (
      output calc_start, calc_re_c, calc_im_c,
      input  calc_done, calc_depth,
      output pix_valid, pix_depth, pix_sof, pix_eol,
      input  pix_ready
   );

   modport slave (
      input  calc_start, calc_re_c, calc_im_c,
      output calc_done, calc_depth,
      input  pix_valid, pix_depth, pix_sof, pix_eol,
      output pix_ready
   );
endinterface

// File: rtl/depth_dispatcher.sv
// depth_dispatcher: scans a WIDTH x HEIGHT frame, hands each pixel's c = (re, im)
// to one depth calculator via start/done and streams the returned depth out.
// Optional feature macro: DISPATCH_PERF_EN adds perf_cycles (busy-cycle counter).
module depth_dispatcher #(
   parameter int unsigned FRAC        = 60,
   parameter int unsigned WORD_LENGTH = 64,
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480
) (
   input  logic                   sysclk,
   input  logic                   reset_n,
   input  logic                   frame_go,
   input  logic [WORD_LENGTH-1:0] re_origin,
   input  logic [WORD_LENGTH-1:0] im_origin,
   input  logic [WORD_LENGTH-1:0] step,
   depth_dispatcher_if.master     bus,
   output logic                   busy,
   output logic                   frame_done
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]            perf_cycles
`endif
);

   localparam int unsigned DEPTH_W = 10;
   localparam int unsigned XW      = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   // The fixed point must keep at least the sign bit as integer part.
   if (FRAC >= WORD_LENGTH) begin : g_bad_frac
      $error("depth_dispatcher: FRAC must be smaller than WORD_LENGTH");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_GAP   = 3'd2,
      S_WAIT  = 3'd3,
      S_EMIT  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t                 state;
   logic [XW-1:0]          x;
   logic [YW-1:0]          y;
   logic [WORD_LENGTH-1:0] re_org;
   logic [WORD_LENGTH-1:0] step_q;
   logic [WORD_LENGTH-1:0] re_acc;
   logic [WORD_LENGTH-1:0] im_acc;

   logic                   calc_start_q;
   logic [WORD_LENGTH-1:0] calc_re_q;
   logic [WORD_LENGTH-1:0] calc_im_q;
   logic                   pix_valid_q;
   logic [DEPTH_W-1:0]     pix_depth_q;
   logic                   pix_sof_q;
   logic                   pix_eol_q;

   logic                   last_x_c;
   logic                   last_y_c;
   logic                   accept_c;
   logic [WORD_LENGTH-1:0] re_next_c;
   logic [WORD_LENGTH-1:0] im_next_c;

   // Scan position and the coordinates of the pixel after the current one
   always_comb begin
      last_x_c  = (x == X_LAST);
      last_y_c  = (y == Y_LAST);
      accept_c  = pix_valid_q && bus.pix_ready;
      re_next_c = re_acc + step_q;
      im_next_c = im_acc;
      if (last_x_c) begin
         re_next_c = re_org;
         im_next_c = im_acc - step_q;
      end
   end

   // Frame scan FSM with registered calculator and pixel-stream outputs
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         x            <= '0;
         y            <= '0;
         re_org       <= '0;
         step_q       <= '0;
         re_acc       <= '0;
         im_acc       <= '0;
         calc_start_q <= 1'b0;
         calc_re_q    <= '0;
         calc_im_q    <= '0;
         pix_valid_q  <= 1'b0;
         pix_depth_q  <= '0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         calc_start_q <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_go) begin
                  re_org       <= re_origin;
                  step_q       <= step;
                  re_acc       <= re_origin;
                  im_acc       <= im_origin;
                  x            <= '0;
                  y            <= '0;
                  busy         <= 1'b1;
                  calc_start_q <= 1'b1;
                  calc_re_q    <= re_origin;
                  calc_im_q    <= im_origin;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_GAP;
            // Done may still show the previous pixel here; skip one cycle.
            S_GAP:   state <= S_WAIT;
            S_WAIT: begin
               if (bus.calc_done) begin
                  pix_depth_q <= bus.calc_depth;
                  pix_valid_q <= 1'b1;
                  pix_sof_q   <= (x == '0) && (y == '0);
                  pix_eol_q   <= last_x_c;
                  state       <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (accept_c) begin
                  pix_valid_q <= 1'b0;
                  pix_sof_q   <= 1'b0;
                  pix_eol_q   <= 1'b0;
                  re_acc      <= re_next_c;
                  im_acc      <= im_next_c;
                  if (last_x_c) begin
                     x <= '0;
                     y <= last_y_c ? '0 : y + YW'(1);
                  end else begin
                     x <= x + XW'(1);
                  end
                  if (last_x_c && last_y_c) begin
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= S_FIN;
                  end else begin
                     calc_start_q <= 1'b1;
                     calc_re_q    <= re_next_c;
                     calc_im_q    <= im_next_c;
                     state        <= S_ISSUE;
                  end
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.calc_start = calc_start_q;
   assign bus.calc_re_c  = calc_re_q;
   assign bus.calc_im_c  = calc_im_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_depth  = pix_depth_q;
   assign bus.pix_sof    = pix_sof_q;
   assign bus.pix_eol    = pix_eol_q;

`ifdef DISPATCH_PERF_EN
   // Busy-cycle counter: restarts on an accepted frame_go, saturates at all-ones
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         perf_cycles <= '0;
      end else if ((state == S_IDLE) && frame_go) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != '1)) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_depth_dispatcher.sv
// tb_depth_dispatcher: randomized frames against a pixel-index reference model.
module tb_depth_dispatcher;

   localparam int unsigned WL   = 64;
   localparam int unsigned W    = 4;
   localparam int unsigned H    = 2;
   localparam int          NPIX = W * H;
   localparam int          TMO  = 3000;

   logic          sysclk = 1'b0;
   logic          reset_n;
   logic          frame_go;
   logic [WL-1:0] re_origin;
   logic [WL-1:0] im_origin;
   logic [WL-1:0] step;
   logic          busy;
   logic          frame_done;
`ifdef DISPATCH_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   depth_dispatcher_if #(.WORD_LENGTH(WL)) bus_if ();

   depth_dispatcher #(
      .FRAC(60), .WORD_LENGTH(WL), .WIDTH(W), .HEIGHT(H)
   ) dut (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .frame_go   (frame_go),
      .re_origin  (re_origin),
      .im_origin  (im_origin),
      .step       (step),
      .bus        (bus_if),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef DISPATCH_PERF_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   always #5 sysclk = ~sysclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Stimulus knobs
   int lat_lo     = 3;
   int lat_hi     = 3;
   bit depth_mode = 1'b1;  // 1: calculator returns start index, 0: hash of c
   bit rnd_ready  = 1'b0;
   int stall_idx  = -1;
   int stall_len  = 0;

   // Reference model state
   int          issue_idx   = 0;
   int          emit_idx    = 0;
   int          frames_done = 0;
   bit          exp_busy    = 1'b0;
   bit          fin_now     = 1'b0;
   bit          hold_prev   = 1'b0;
   logic [63:0] org_re      = '0;
   logic [63:0] org_im      = '0;
   logic [63:0] org_step    = '0;
   longint      perf_exp    = 0;

   function automatic logic [9:0] hsh(input logic [63:0] re, input logic [63:0] im);
      return 10'(re ^ (re >> 50) ^ (im >> 40) ^ (im >> 54) ^ (im >> 7));
   endfunction

   function automatic logic [63:0] exp_re(input int idx);
      return org_re + org_step * 64'(idx % W);
   endfunction

   function automatic logic [63:0] exp_im(input int idx);
      return org_im - org_step * 64'(idx / W);
   endfunction

   function automatic logic [9:0] exp_depth(input int idx);
      return depth_mode ? 10'(idx) : hsh(exp_re(idx), exp_im(idx));
   endfunction

   // Calculator model: done is a level cleared on start, set after a random latency
   int          lat_cnt   = 0;
   int          start_cnt = 0;
   logic [9:0]  held_depth;
   always @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         bus_if.calc_done  <= 1'b0;
         bus_if.calc_depth <= '0;
         lat_cnt           <= 0;
         start_cnt         <= 0;
         held_depth        <= '0;
      end else if (bus_if.calc_start) begin
         bus_if.calc_done  <= 1'b0;
         bus_if.calc_depth <= 10'($urandom);
         lat_cnt           <= int'($urandom_range(lat_hi, lat_lo));
         held_depth        <= depth_mode ? 10'(start_cnt)
                                         : hsh(bus_if.calc_re_c, bus_if.calc_im_c);
         start_cnt         <= start_cnt + 1;
      end else begin
         if (frame_go && !busy) start_cnt <= 0;
         if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
               bus_if.calc_done  <= 1'b1;
               bus_if.calc_depth <= held_depth;
            end
         end
      end
   end

   // Pixel sink: random backpressure or a directed stall on one pixel
   initial begin
      int stalled;
      stalled = 0;
      bus_if.pix_ready = 1'b0;
      forever begin
         @(posedge sysclk);
         #1;
         if (rnd_ready) begin
            bus_if.pix_ready = ($urandom_range(3, 0) != 0);
         end else if (bus_if.pix_valid && (emit_idx == stall_idx) && (stalled < stall_len)) begin
            bus_if.pix_ready = 1'b0;
            stalled++;
         end else begin
            bus_if.pix_ready = 1'b1;
         end
         if (emit_idx != stall_idx) stalled = 0;
      end
   end

   // Monitor: compare every cycle against the model, then advance the model
   always @(negedge sysclk) begin
      bit nxt_fin;
      if (!reset_n) begin
         issue_idx = 0;
         emit_idx  = 0;
         exp_busy  = 1'b0;
         fin_now   = 1'b0;
         hold_prev = 1'b0;
         perf_exp  = 0;
      end else begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("frame_done", 64'(frame_done), 64'(fin_now));
         if (hold_prev) chk("valid_hold", 64'(bus_if.pix_valid), 64'd1);
         if (bus_if.calc_start) begin
            chk("start_order", 64'(issue_idx), 64'(emit_idx));
            chk("calc_re_c", bus_if.calc_re_c, exp_re(issue_idx));
            chk("calc_im_c", bus_if.calc_im_c, exp_im(issue_idx));
            issue_idx++;
         end
         if (bus_if.pix_valid) begin
            chk("pix_pending", 64'(issue_idx), 64'(emit_idx + 1));
            chk("pix_depth", 64'(bus_if.pix_depth), 64'(exp_depth(emit_idx)));
            chk("pix_sof", 64'(bus_if.pix_sof), 64'(emit_idx == 0));
            chk("pix_eol", 64'(bus_if.pix_eol), 64'((emit_idx % W) == W - 1));
         end
`ifdef DISPATCH_PERF_EN
         chk("perf_cycles", 64'(perf_cycles), 64'(perf_exp));
         if (exp_busy) perf_exp++;
`endif
         nxt_fin   = 1'b0;
         hold_prev = bus_if.pix_valid && !bus_if.pix_ready;
         if (bus_if.pix_valid && bus_if.pix_ready) begin
            emit_idx++;
            if (emit_idx == NPIX) begin
               exp_busy = 1'b0;
               nxt_fin  = 1'b1;
               frames_done++;
            end
         end
         if (frame_go && !exp_busy && !fin_now) begin
            exp_busy  = 1'b1;
            org_re    = re_origin;
            org_im    = im_origin;
            org_step  = step;
            issue_idx = 0;
            emit_idx  = 0;
            perf_exp  = 0;
         end
         fin_now = nxt_fin;
      end
   end

   task automatic check_reset_outputs();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_calc_start", 64'(bus_if.calc_start), 64'd0);
      chk("rst_calc_re_c", bus_if.calc_re_c, 64'd0);
      chk("rst_calc_im_c", bus_if.calc_im_c, 64'd0);
      chk("rst_pix_valid", 64'(bus_if.pix_valid), 64'd0);
      chk("rst_pix_depth", 64'(bus_if.pix_depth), 64'd0);
      chk("rst_pix_sof", 64'(bus_if.pix_sof), 64'd0);
      chk("rst_pix_eol", 64'(bus_if.pix_eol), 64'd0);
`ifdef DISPATCH_PERF_EN
      chk("rst_perf_cycles", 64'(perf_cycles), 64'd0);
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   // One frame; optional frame_go mid-frame (new origin) and in the FIN cycle
   task automatic run_frame(input logic [63:0] ro, input logic [63:0] io,
                            input logic [63:0] st, input int midgo, input bit go_at_fin);
      int f0;
      f0 = frames_done;
      re_origin = ro;
      im_origin = io;
      step      = st;
      frame_go  = 1'b1;
      idle(1);
      frame_go  = 1'b0;
      re_origin = {$urandom, $urandom};
      im_origin = {$urandom, $urandom};
      step      = {$urandom, $urandom};
      for (int c = 0; (c < TMO) && (frames_done == f0); c++) begin
         frame_go = (c == midgo);
         if (frame_go) begin
            re_origin = {$urandom, $urandom};
            im_origin = {$urandom, $urandom};
            step      = {$urandom, $urandom};
         end
         idle(1);
      end
      frame_go = 1'b0;
      chk("frame_timeout", 64'(frames_done != f0), 64'd1);
      if (go_at_fin) begin
         frame_go = 1'b1;
         idle(1);
         frame_go = 1'b0;
      end
      idle(3);
   endtask

   initial begin
      reset_n   = 1'b0;
      frame_go  = 1'b0;
      re_origin = '0;
      im_origin = '0;
      step      = '0;
      #1;
      check_reset_outputs();
      idle(3);
      reset_n = 1'b1;
      idle(2);

      // Directed frame: c from -2.0+1.0i, step 0.5, stall 5 cycles on pixel 2
      depth_mode = 1'b1;
      rnd_ready  = 1'b0;
      stall_idx  = 2;
      stall_len  = 5;
      lat_lo     = 3;
      lat_hi     = 3;
      run_frame(64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                64'h0800_0000_0000_0000, -1, 1'b1);
      chk("idle_after_fin_go", 64'(busy), 64'd0);

      // Random latency and backpressure, frame_go mid-frame with a new origin
      stall_idx  = -1;
      depth_mode = 1'b0;
      rnd_ready  = 1'b1;
      lat_lo     = 1;
      lat_hi     = 6;
      run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 12, 1'b0);

      // Asynchronous reset while pixel 5 is in flight
      depth_mode = 1'b1;
      rnd_ready  = 1'b0;
      lat_lo     = 3;
      lat_hi     = 3;
      re_origin  = {$urandom, $urandom};
      im_origin  = {$urandom, $urandom};
      step       = {$urandom, $urandom};
      frame_go   = 1'b1;
      idle(1);
      frame_go   = 1'b0;
      for (int c = 0; (c < TMO) && (emit_idx != 5); c++) idle(1);
      chk("reach_pixel5", 64'(emit_idx), 64'd5);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      idle(2);
      reset_n = 1'b1;
      idle(2);

      // Restart from (0,0) after reset
      run_frame(64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
                64'h0800_0000_0000_0000, -1, 1'b0);

      // Random frames
      depth_mode = 1'b0;
      rnd_ready  = 1'b1;
      lat_lo     = 1;
      lat_hi     = 6;
      for (int f = 0; f < 5; f++) begin
         run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(40, 0)), 1'($urandom_range(1, 0)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound on simulation time
   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before 400000");
      $fatal(1, "watchdog expired");
   end

endmodule
